sr_flag_bank: RTL and testbench
===============================

// Module: sr_flag_bank
// PURPOSE
//   CHANNELS-wide bank of clocked set/reset flags. Replaces the level-sensitive
//   SR latch wherever flags feed synchronous logic such as status, interrupt-pending
//   and busy bits. Adds a selectable S=R=1 resolution, a software clear and
//   per-channel edge pulses. Also counts S=R=1 conflict events with saturation.
// PARAMETERS
//   CHANNELS       8      number of independent SR flag channels (1..32)
//   CONFLICT_MODE  0      S=R=1 resolution: 0 HOLD, 1 SET-dom, 2 RESET-dom, 3 TOGGLE
//   INIT_Q         0      CHANNELS-bit value loaded into q on reset
//   CNT_W          4      width of the saturating conflict counter
// PORTS
//   clk        in   1         sole clock; all state updates on rising edge
//   rst        in   1         synchronous, active-high reset
//   s          in   CHANNELS  per-channel set request, sampled each clk
//   r          in   CHANNELS  per-channel reset request, sampled each clk
//   clr_we     in   1         software clear strobe
//   clr_mask   in   CHANNELS  channels forced to 0 when clr_we=1
//   clr_cnt    in   1         clear the conflict counter
//   q          out  CHANNELS  flag state (registered)
//   qbar       out  CHANNELS  always exactly ~q; no invalid Q=Qbar state exists
//   rise       out  CHANNELS  1-cycle pulse in the first cycle q[i] reads 1 after 0
//   fall       out  CHANNELS  1-cycle pulse in the first cycle q[i] reads 0 after 1
//   conflict   out  CHANNELS  1-cycle registered pulse: s[i]&r[i] seen last cycle
//   any_q      out  1         |q (combinational from q)
//   conflict_cnt out CNT_W    saturating count of conflict events
// BEHAVIOUR
//   - Reset (rst=1 at edge): q<=INIT_Q, rise=fall=conflict=0, conflict_cnt=0.
//     rst overrides every other input. No rise/fall pulse on the first
//     post-reset cycle, even when INIT_Q bits are 1.
//   - Latency: s/r/clr sampled at edge N, so q reflects them after edge N.
//     rise/fall/conflict assert in that same cycle and clear one cycle later
//     unless retriggered.
//   - Per-channel next state, priority high->low:
//     clr_we&clr_mask[i] -> 0; s=1,r=0 -> 1; s=0,r=1 -> 0; s=r=0 -> hold;
//     s=r=1 -> by CONFLICT_MODE: HOLD keeps q, SET gives 1, RESET gives 0,
//     TOGGLE gives ~q.
//   - conflict[i] is set for s[i]&r[i] even when a software clear masks the
//     channel's next state.
//   - rise[i] = q_new & ~q_old; fall[i] = ~q_new & q_old. TOGGLE with s=r=1
//     held gives q alternating every cycle, with rise/fall alternating.
//   - conflict_cnt increments by popcount(s&r) per cycle. The sum is computed
//     at CNT_W+$clog2(CHANNELS)+1 bits and clamped at 2^CNT_W-1; it never wraps.
//   - clr_cnt=1: conflict_cnt <= min(popcount(s&r), max), so events in the
//     clear cycle are not lost.
//   - Channels are independent; no cross-channel priority exists.
//   - s/r must be synchronous to clk; no metastability handling inside.
//   - Reset mid-operation discards in-flight edges and pending pulses.
// STRUCTURE
//   - Package sr_pkg: localparams SR_HOLD=0, SR_SET=1, SR_RESET=2, SR_TOGGLE=3;
//     function popcount(); SR_MODE_W=2 typedef.
//   - Sub-module sr_cell (one channel): next-state mux, q register,
//     rise/fall/conflict registers. Instantiated CHANNELS times via generate.
//   - Top level keeps the popcount, the saturating counter and any_q.
// TESTING
//   1 Reset: INIT_Q=8'hA5, rst 2 cycles -> q=A5, qbar=5A; rise=fall=0,
//     conflict_cnt=0 on the first free cycle.
//   2 Set/reset: s=01 one cycle -> next cycle q[0]=1, rise=01;
//     following cycle rise=00. Then r=01 -> q[0]=0, fall=01.
//   3 Conflict, all four modes: q[0]=1, s=r=01 -> HOLD:1, SET:1, RESET:0
//     with fall=01, TOGGLE:0; conflict=01 in every mode.
//   4 TOGGLE, s=r=01 held 4 cycles -> q[0] sequence 1,0,1,0.
//     rise/fall alternate; conflict_cnt=4.
//   5 Saturation: CNT_W=4, s=r=FF for 2 cycles -> cnt 8 then 15.
//     Held further -> stays 15. clr_cnt with s&r=03 -> cnt=2.
//   6 Clear priority: q=FF, s=0F, clr_we=1, clr_mask=F0 -> q=0F, fall=F0.
//     A mid-stream rst -> q=INIT_Q, and no edge pulses follow.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the clocked set/reset flag bank: conflict-resolution
// mode encoding and a population-count helper used by the conflict counter.
package sr_pkg;

  localparam int SR_MODE_W = 2;
  typedef logic [SR_MODE_W-1:0] sr_mode_t;

  localparam sr_mode_t SR_HOLD   = 2'd0;
  localparam sr_mode_t SR_SET    = 2'd1;
  localparam sr_mode_t SR_RESET  = 2'd2;
  localparam sr_mode_t SR_TOGGLE = 2'd3;

  localparam int POP_IN_W  = 32;
  localparam int POP_OUT_W = 6;

  // Number of set bits in a vector of up to 32 channels.
  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      cnt = cnt + POP_OUT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked set/reset flag: next-state mux with software clear and
// configurable S=R=1 resolution, plus registered rise/fall/conflict pulses.
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_t MODE = SR_HOLD,
  parameter logic     INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr,
  output logic q,
  output logic rise,
  output logic fall,
  output logic conflict
);

  logic q_next;

  // NOTE: q_next gets a default first so no path through the block leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = 1'b0;
    end else begin
      unique case ({s, r})
        2'b10:   q_next = 1'b1;
        2'b01:   q_next = 1'b0;
        2'b00:   q_next = q;
        2'b11: begin
          case (MODE)
            SR_SET:    q_next = 1'b1;
            SR_RESET:  q_next = 1'b0;
            SR_TOGGLE: q_next = ~q;
            default:   q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of q, which the edge detectors rely on.
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= INIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      q        <= q_next;
      rise     <= q_next & ~q;
      fall     <= ~q_next & q;
      // Reported even when the clear overrides the channel's next state.
      conflict <= s & r;
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CHANNELS independent clocked SR flags with software clear, edge
// pulses, and a saturating counter of S=R=1 conflict events.
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int                  CHANNELS      = 8,
  parameter int                  CONFLICT_MODE = 0,
  parameter logic [CHANNELS-1:0] INIT_Q        = '0,
  parameter int                  CNT_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic                clr_we,
  input  logic [CHANNELS-1:0] clr_mask,
  input  logic                clr_cnt,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qbar,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] conflict,
  output logic                any_q,
  output logic [CNT_W-1:0]    conflict_cnt
);

  // Wide enough to add a full-scale counter and an all-channel popcount.
  localparam int SUM_W = CNT_W + $clog2(CHANNELS) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam sr_mode_t MODE = sr_mode_t'(CONFLICT_MODE);

  logic [CHANNELS-1:0] clr_vec;
  logic [POP_IN_W-1:0] both_ext;
  logic [SUM_W-1:0]    pop_w;
  logic [SUM_W-1:0]    sum_w;
  logic [SUM_W-1:0]    base_w;
  logic [CNT_W-1:0]    cnt_next;

  assign clr_vec = {CHANNELS{clr_we}} & clr_mask;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    sr_cell #(
      .MODE (MODE),
      .INIT (INIT_Q[i])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s        (s[i]),
      .r        (r[i]),
      .clr      (clr_vec[i]),
      .q        (q[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .conflict (conflict[i])
    );
  end

  assign qbar  = ~q;
  assign any_q = |q;

  // Events in a clear cycle seed the counter rather than being dropped.
  always_comb begin
    both_ext = POP_IN_W'(s & r);
    pop_w    = SUM_W'(popcount(both_ext));
    sum_w    = SUM_W'(conflict_cnt) + pop_w;
    base_w   = clr_cnt ? pop_w : sum_w;
    cnt_next = (base_w > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(base_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else begin
      conflict_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Self-checking bench: four banks (one per conflict mode) share stimulus and
// are compared every cycle against a behavioural model, directed and random.
module tb_sr_flag_bank;

  localparam int         NM   = 4;
  localparam logic [7:0] INIT = 8'hA5;

  logic       clk;
  logic       rst;
  logic [7:0] s, r, clr_mask;
  logic       clr_we, clr_cnt;

  logic [7:0] q_o    [NM];
  logic [7:0] qbar_o [NM];
  logic [7:0] rise_o [NM];
  logic [7:0] fall_o [NM];
  logic [7:0] conf_o [NM];
  logic       any_o  [NM];
  logic [3:0] cnt_o  [NM];

  for (genvar m = 0; m < NM; m++) begin : g_dut
    sr_flag_bank #(
      .CHANNELS      (8),
      .CONFLICT_MODE (m),
      .INIT_Q        (INIT),
      .CNT_W         (4)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s            (s),
      .r            (r),
      .clr_we       (clr_we),
      .clr_mask     (clr_mask),
      .clr_cnt      (clr_cnt),
      .q            (q_o[m]),
      .qbar         (qbar_o[m]),
      .rise         (rise_o[m]),
      .fall         (fall_o[m]),
      .conflict     (conf_o[m]),
      .any_q        (any_o[m]),
      .conflict_cnt (cnt_o[m])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flag values per mode, pulses, and an integer counter.
  logic [7:0] mq    [NM];
  logic [7:0] mrise [NM];
  logic [7:0] mfall [NM];
  logic [7:0] mconf;
  int         mcnt;

  task automatic model_step(input logic [7:0] si, ri, input logic cwe,
                            input logic [7:0] cmask, input logic ccnt, input logic rsti);
    int n;
    if (rsti) begin
      for (int m = 0; m < NM; m++) begin
        mq[m] = INIT; mrise[m] = '0; mfall[m] = '0;
      end
      mconf = '0;
      mcnt  = 0;
      return;
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      mconf[i] = si[i] & ri[i];
      if (mconf[i]) n++;
    end
    for (int m = 0; m < NM; m++) begin
      for (int i = 0; i < 8; i++) begin
        logic old_b, new_b;
        old_b = mq[m][i];
        if (cwe && cmask[i])       new_b = 1'b0;
        else if (si[i] && !ri[i])  new_b = 1'b1;
        else if (!si[i] && ri[i])  new_b = 1'b0;
        else if (!si[i] && !ri[i]) new_b = old_b;
        else if (m == 1)           new_b = 1'b1;
        else if (m == 2)           new_b = 1'b0;
        else if (m == 3)           new_b = !old_b;
        else                       new_b = old_b;
        mq[m][i]    = new_b;
        mrise[m][i] = new_b && !old_b;
        mfall[m][i] = !new_b && old_b;
      end
    end
    mcnt = ccnt ? n : mcnt + n;
    if (mcnt > 15) mcnt = 15;
  endtask

  task automatic compare_all();
    for (int m = 0; m < NM; m++) begin
      logic [7:0] nq;
      nq = ~mq[m];
      check($sformatf("m%0d_q", m),        q_o[m],    mq[m]);
      check($sformatf("m%0d_qbar", m),     qbar_o[m], nq);
      check($sformatf("m%0d_rise", m),     rise_o[m], mrise[m]);
      check($sformatf("m%0d_fall", m),     fall_o[m], mfall[m]);
      check($sformatf("m%0d_conflict", m), conf_o[m], mconf);
      check($sformatf("m%0d_any_q", m),    any_o[m],  |mq[m]);
      check($sformatf("m%0d_cnt", m),      cnt_o[m],  mcnt);
    end
  endtask

  // Called with clk low; drives inputs, takes one edge, checks at the falling edge.
  task automatic cycle(input logic [7:0] si, ri, input logic cwe,
                       input logic [7:0] cmask, input logic ccnt, input logic rsti);
    s = si; r = ri; clr_we = cwe; clr_mask = cmask; clr_cnt = ccnt; rst = rsti;
    @(posedge clk);
    model_step(si, ri, cwe, cmask, ccnt, rsti);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [7:0]  s, r;
    logic        cwe;
    logic [7:0]  cmask;
    logic        ccnt;
    logic        rst;
    logic [31:0] eq;    // expected q per mode: {TOGGLE, RESET, SET, HOLD}
    logic [7:0]  econf;
    int          ecnt;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] si, ri, input logic cwe,
                              input logic [7:0] cmask, input logic ccnt,
                              input logic rsti, input logic [31:0] eq,
                              input logic [7:0] econf, input int ecnt);
    vec_t v;
    v.s = si; v.r = ri; v.cwe = cwe; v.cmask = cmask; v.ccnt = ccnt; v.rst = rsti;
    v.eq = eq; v.econf = econf; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    logic [7:0] ttab [4];
    s = '0; r = '0; clr_we = 1'b0; clr_mask = '0; clr_cnt = 1'b0; rst = 1'b1;
    for (int m = 0; m < NM; m++) begin
      mq[m] = INIT; mrise[m] = '0; mfall[m] = '0;
    end
    mconf = '0; mcnt = 0;

    //              s      r      we  mask   cc   rst   q {T,R,S,H}                       conf   cnt
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 1, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 1, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 0, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h01, 0, 8'h00, 0, 0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 8'h00, 0));
    vecs.push_back(mk(8'h01, 8'h00, 0, 8'h00, 0, 0, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 0, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h01, 0, 8'h00, 0, 0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 8'h00, 0));
    vecs.push_back(mk(8'h01, 8'h00, 0, 8'h00, 0, 0, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h01, 8'h01, 0, 8'h00, 0, 0, {8'hA4, 8'hA4, 8'hA5, 8'hA5}, 8'h01, 1));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 0, {8'hA4, 8'hA4, 8'hA5, 8'hA5}, 8'h00, 1));
    vecs.push_back(mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00, 1));
    vecs.push_back(mk(8'h0F, 8'h00, 1, 8'hF0, 0, 0, {8'h0F, 8'h0F, 8'h0F, 8'h0F}, 8'h00, 1));
    vecs.push_back(mk(8'hFF, 8'hFF, 1, 8'hFF, 0, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 9));
    vecs.push_back(mk(8'h03, 8'h03, 0, 8'h00, 1, 0, {8'h03, 8'h00, 8'h03, 8'h00}, 8'h03, 2));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 1, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'hFF, 8'hFF, 0, 8'h00, 0, 0, {8'h5A, 8'h00, 8'hFF, 8'hA5}, 8'hFF, 8));
    vecs.push_back(mk(8'hFF, 8'hFF, 0, 8'h00, 0, 0, {8'hA5, 8'h00, 8'hFF, 8'hA5}, 8'hFF, 15));
    vecs.push_back(mk(8'hFF, 8'hFF, 0, 8'h00, 0, 0, {8'h5A, 8'h00, 8'hFF, 8'hA5}, 8'hFF, 15));
    vecs.push_back(mk(8'h03, 8'h03, 0, 8'h00, 1, 0, {8'h59, 8'h00, 8'hFF, 8'hA5}, 8'h03, 2));
    vecs.push_back(mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));
    vecs.push_back(mk(8'h00, 8'h00, 0, 8'h00, 0, 0, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'h00, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      cycle(vecs[k].s, vecs[k].r, vecs[k].cwe, vecs[k].cmask, vecs[k].ccnt, vecs[k].rst);
      for (int m = 0; m < NM; m++) begin
        check($sformatf("vec%0d_m%0d_q", k, m), q_o[m], vecs[k].eq[8*m +: 8]);
      end
      check($sformatf("vec%0d_conflict", k), conf_o[0], vecs[k].econf);
      check($sformatf("vec%0d_cnt", k), cnt_o[0], vecs[k].ecnt);
    end

    // TOGGLE held: q[0] 1,0,1,0 with alternating rise/fall, four conflict events.
    cycle(8'h00, 8'h00, 0, 8'h00, 0, 1);
    cycle(8'h00, 8'h01, 0, 8'h00, 0, 0);
    ttab[0] = 8'h01; ttab[1] = 8'h00; ttab[2] = 8'h01; ttab[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      cycle(8'h01, 8'h01, 0, 8'h00, 0, 0);
      check($sformatf("tog%0d_q0", k),    q_o[3][0],    ttab[k][0]);
      check($sformatf("tog%0d_rise0", k), rise_o[3][0], ttab[k][0]);
      check($sformatf("tog%0d_fall0", k), fall_o[3][0], !ttab[k][0]);
    end
    check("tog_cnt", cnt_o[3], 4);

    // Reset right after a rising edge: the pending pulse is discarded.
    cycle(8'hFF, 8'h00, 0, 8'h00, 0, 0);
    cycle(8'h00, 8'h00, 0, 8'h00, 0, 1);
    check("rst_rise", rise_o[1], 8'h00);
    check("rst_fall", fall_o[1], 8'h00);
    cycle(8'h00, 8'h00, 0, 8'h00, 0, 0);
    check("post_rst_rise", rise_o[1], 8'h00);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [7:0] rs, rr, rm;
      rs = 8'($urandom);
      rr = 8'($urandom);
      rm = 8'($urandom);
      cycle(rs, rr, ($urandom_range(0, 7) == 0), rm,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
